// File: rtl/iq_integrate_dump_pkg.sv
// Shared types and constants for the I/Q integrate-and-dump stage.
// Default widths match the upstream MSB-truncation stage.
package iq_integrate_dump_pkg;

  // Integration FSM: idle until the first symbol sync, then integrate.
  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    INTEGRATE = 1'b1
  } state_e;

  localparam int DEF_I_WIDTH   = 16;
  localparam int DEF_O_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH = 24;

  // Width of a counter that must reach at least len-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len);
    cnt_width = (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iq_shift_reduce.sv
// Arithmetic right shift of one branch's window sum followed by width reduction.
// IQ_INTDUMP_SAT_EN selects saturation (with clip flag) instead of wrap truncation.
module iq_shift_reduce
  import iq_integrate_dump_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int O_WIDTH   = DEF_O_WIDTH,
  parameter int SHIFT     = 4
) (
  input  logic signed [ACC_WIDTH-1:0] i_sum,
  output logic        [O_WIDTH-1:0]   o_data
`ifdef IQ_INTDUMP_SAT_EN
  ,
  output logic                        o_clip
`endif
);

  logic signed [ACC_WIDTH-1:0] w_shifted;

  assign w_shifted = i_sum >>> SHIFT;

`ifdef IQ_INTDUMP_SAT_EN
  // Output range limits expressed at accumulator width for a signed compare.
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  // Clamp the shifted sum to the signed output range and flag any clipping.
  always_comb begin
    o_data = O_WIDTH'(w_shifted);
    o_clip = 1'b0;
    if (w_shifted > MAX_V) begin
      o_data = MAX_V[O_WIDTH-1:0];
      o_clip = 1'b1;
    end else if (w_shifted < MIN_V) begin
      o_data = MIN_V[O_WIDTH-1:0];
      o_clip = 1'b1;
    end else begin
      o_data = O_WIDTH'(w_shifted);
      o_clip = 1'b0;
    end
  end
`else
  // Two's-complement wrap: keep only the low O_WIDTH bits.
  assign o_data = O_WIDTH'(w_shifted);
`endif

endmodule

// File: rtl/iq_integrate_dump.sv
// I/Q integrate-and-dump: sums DUMP_LEN jointly-valid samples per branch after
// the first symbol sync and emits one shifted/reduced pair per window.
// Optional macro IQ_INTDUMP_SAT_EN: saturating reduction plus sat_flag output.
module iq_integrate_dump
  import iq_integrate_dump_pkg::*;
#(
  parameter int I_WIDTH   = DEF_I_WIDTH,
  parameter int O_WIDTH   = DEF_O_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int DUMP_LEN  = 16,
  parameter int SHIFT     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [I_WIDTH-1:0] I_tdata,
  input  logic               I_tvalid,
  input  logic [I_WIDTH-1:0] Q_tdata,
  input  logic               Q_tvalid,
  input  logic               sym_sync,
  output logic [O_WIDTH-1:0] I_out_tdata,
  output logic [O_WIDTH-1:0] Q_out_tdata,
  output logic               out_tvalid
`ifdef IQ_INTDUMP_SAT_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int CNT_W = cnt_width(DUMP_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);
  localparam logic ONE_LEN = (DUMP_LEN == 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

  state_e                      r_state, w_state_nxt;
  logic signed [ACC_WIDTH-1:0] r_acc_i, r_acc_q, w_acc_i_nxt, w_acc_q_nxt;
  logic        [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic        [O_WIDTH-1:0]   r_out_i, r_out_q, w_red_i, w_red_q;
  logic                        r_out_valid;
  logic                        w_accept, w_dump;
  logic signed [ACC_WIDTH-1:0] w_sx_i, w_sx_q, w_sum_i, w_sum_q;
`ifdef IQ_INTDUMP_SAT_EN
  logic                        r_sat, w_clip_i, w_clip_q;
`endif

  assign w_accept = I_tvalid & Q_tvalid;
  assign w_sx_i   = ACC_WIDTH'($signed(I_tdata));
  assign w_sx_q   = ACC_WIDTH'($signed(Q_tdata));
  // A sync discards the running sum, so the sample then starts a fresh window.
  assign w_sum_i  = (sym_sync ? ACC_ZERO : r_acc_i) + w_sx_i;
  assign w_sum_q  = (sym_sync ? ACC_ZERO : r_acc_q) + w_sx_q;

  iq_shift_reduce #(.ACC_WIDTH(ACC_WIDTH), .O_WIDTH(O_WIDTH), .SHIFT(SHIFT)) u_red_i (
    .i_sum  (w_sum_i),
    .o_data (w_red_i)
`ifdef IQ_INTDUMP_SAT_EN
    ,
    .o_clip (w_clip_i)
`endif
  );

  iq_shift_reduce #(.ACC_WIDTH(ACC_WIDTH), .O_WIDTH(O_WIDTH), .SHIFT(SHIFT)) u_red_q (
    .i_sum  (w_sum_q),
    .o_data (w_red_q)
`ifdef IQ_INTDUMP_SAT_EN
    ,
    .o_clip (w_clip_q)
`endif
  );

  // Next-state, accumulator and dump decision; sync takes priority over dump.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_i_nxt = r_acc_i;
    w_acc_q_nxt = r_acc_q;
    w_cnt_nxt   = r_cnt;
    w_dump      = 1'b0;
    case (r_state)
      WAIT_SYNC: begin
        if (sym_sync) begin
          w_state_nxt = INTEGRATE;
          if (w_accept) begin
            w_acc_i_nxt = w_sx_i;
            w_acc_q_nxt = w_sx_q;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_acc_i_nxt = ACC_ZERO;
            w_acc_q_nxt = ACC_ZERO;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end
        end else begin
          w_state_nxt = WAIT_SYNC;
        end
      end
      INTEGRATE: begin
        if (sym_sync && w_accept && ONE_LEN) begin
          // Single-sample windows: the restart sample is itself a full window.
          w_dump      = 1'b1;
          w_acc_i_nxt = ACC_ZERO;
          w_acc_q_nxt = ACC_ZERO;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (sym_sync && w_accept) begin
          w_acc_i_nxt = w_sx_i;
          w_acc_q_nxt = w_sx_q;
          w_cnt_nxt   = CNT_W'(1);
        end else if (sym_sync) begin
          w_acc_i_nxt = ACC_ZERO;
          w_acc_q_nxt = ACC_ZERO;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (w_accept && (r_cnt >= LAST_CNT)) begin
          w_dump      = 1'b1;
          w_acc_i_nxt = ACC_ZERO;
          w_acc_q_nxt = ACC_ZERO;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (w_accept) begin
          w_acc_i_nxt = w_sum_i;
          w_acc_q_nxt = w_sum_q;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = WAIT_SYNC;
        w_acc_i_nxt = ACC_ZERO;
        w_acc_q_nxt = ACC_ZERO;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, accumulator and sample-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_SYNC;
      r_acc_i <= ACC_ZERO;
      r_acc_q <= ACC_ZERO;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_acc_i <= w_acc_i_nxt;
      r_acc_q <= w_acc_q_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output registers: data holds between dumps, valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_i     <= {O_WIDTH{1'b0}};
      r_out_q     <= {O_WIDTH{1'b0}};
      r_out_valid <= 1'b0;
`ifdef IQ_INTDUMP_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else if (w_dump) begin
      r_out_i     <= w_red_i;
      r_out_q     <= w_red_q;
      r_out_valid <= 1'b1;
`ifdef IQ_INTDUMP_SAT_EN
      r_sat       <= w_clip_i | w_clip_q;
`endif
    end else begin
      r_out_valid <= 1'b0;
`ifdef IQ_INTDUMP_SAT_EN
      r_sat       <= 1'b0;
`endif
    end
  end

  assign I_out_tdata = r_out_i;
  assign Q_out_tdata = r_out_q;
  assign out_tvalid  = r_out_valid;
`ifdef IQ_INTDUMP_SAT_EN
  assign sat_flag    = r_sat;
`endif

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Bench for iq_integrate_dump: three instances (default, SHIFT=2, DUMP_LEN=1)
// share one directed stimulus stream and are checked every cycle against a
// window-sum model, plus literal expectations from hand calculation.
module tb_iq_integrate_dump;

`ifdef IQ_INTDUMP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] I_tdata, Q_tdata;
  logic        I_tvalid, Q_tvalid, sym_sync;
  logic [15:0] o_i [3];
  logic [15:0] o_q [3];
  logic        o_v [3];
  logic        o_s [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int pulses0 = 0;

  // Model state per instance: synced flag, samples in window, window sums.
  bit     m_sync [3];
  int     m_n    [3];
  longint m_si   [3];
  longint m_sq   [3];
  int     e_i    [3];
  int     e_q    [3];
  bit     e_v    [3];
  bit     e_s    [3];

  always #5 clk = ~clk;

  iq_integrate_dump dut0 (
    .clk(clk), .rst(rst), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .Q_tdata(Q_tdata), .Q_tvalid(Q_tvalid), .sym_sync(sym_sync),
    .I_out_tdata(o_i[0]), .Q_out_tdata(o_q[0]), .out_tvalid(o_v[0])
`ifdef IQ_INTDUMP_SAT_EN
    , .sat_flag(o_s[0])
`endif
  );

  iq_integrate_dump #(.SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .Q_tdata(Q_tdata), .Q_tvalid(Q_tvalid), .sym_sync(sym_sync),
    .I_out_tdata(o_i[1]), .Q_out_tdata(o_q[1]), .out_tvalid(o_v[1])
`ifdef IQ_INTDUMP_SAT_EN
    , .sat_flag(o_s[1])
`endif
  );

  iq_integrate_dump #(.DUMP_LEN(1), .SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .Q_tdata(Q_tdata), .Q_tvalid(Q_tvalid), .sym_sync(sym_sync),
    .I_out_tdata(o_i[2]), .Q_out_tdata(o_q[2]), .out_tvalid(o_v[2])
`ifdef IQ_INTDUMP_SAT_EN
    , .sat_flag(o_s[2])
`endif
  );

`ifndef IQ_INTDUMP_SAT_EN
  initial begin
    o_s[0] = 1'b0;
    o_s[1] = 1'b0;
    o_s[2] = 1'b0;
  end
`endif

  function automatic int len_of(input int k);
    return (k == 2) ? 1 : 16;
  endfunction

  function automatic int shift_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 0);
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scale a window sum to the 16-bit output, wrapping or clamping.
  task automatic reduce(input longint s, input int sh, output int v, output bit clip);
    longint t;
    logic [15:0] lo;
    t = s >>> sh;
    clip = 1'b0;
    if (SAT && t > 32767) begin
      v = 32767; clip = 1'b1;
    end else if (SAT && t < -32768) begin
      v = -32768; clip = 1'b1;
    end else begin
      lo = t[15:0];
      v = int'($signed(lo));
    end
  endtask

  task automatic emit(input int k, input longint si, input longint sq);
    int vi, vq;
    bit ci, cq;
    reduce(si, shift_of(k), vi, ci);
    reduce(sq, shift_of(k), vq, cq);
    e_i[k] = vi;
    e_q[k] = vq;
    e_v[k] = 1'b1;
    e_s[k] = ci | cq;
  endtask

  // Advance the model of instance k by one clock using the current inputs.
  task automatic model_step(input int k);
    bit acc;
    longint si, sq;
    acc = I_tvalid && Q_tvalid;
    si  = longint'(sx16(I_tdata));
    sq  = longint'(sx16(Q_tdata));
    e_v[k] = 1'b0;
    e_s[k] = 1'b0;
    if (rst) begin
      m_sync[k] = 1'b0; m_n[k] = 0; m_si[k] = 0; m_sq[k] = 0;
      e_i[k] = 0; e_q[k] = 0;
    end else if (sym_sync) begin
      if (acc && m_sync[k] && len_of(k) == 1) begin
        emit(k, si, sq);
        m_n[k] = 0; m_si[k] = 0; m_sq[k] = 0;
      end else begin
        m_n[k]  = acc ? 1 : 0;
        m_si[k] = acc ? si : 0;
        m_sq[k] = acc ? sq : 0;
      end
      m_sync[k] = 1'b1;
    end else if (m_sync[k] && acc) begin
      m_si[k] += si;
      m_sq[k] += sq;
      m_n[k]++;
      if (m_n[k] >= len_of(k)) begin
        emit(k, m_si[k], m_sq[k]);
        m_n[k] = 0; m_si[k] = 0; m_sq[k] = 0;
      end
    end
  endtask

  task automatic step(input bit iv, input bit qv, input int di, input int dq, input bit sy);
    I_tvalid = iv;
    Q_tvalid = qv;
    I_tdata  = 16'(di);
    Q_tdata  = 16'(dq);
    sym_sync = sy;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  // Every-cycle comparison of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (o_v[0] === 1'b1) pulses0++;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("i_out[%0d]", k), sx16(o_i[k]), e_i[k]);
          check($sformatf("q_out[%0d]", k), sx16(o_q[k]), e_q[k]);
          check($sformatf("valid[%0d]", k), int'(o_v[k]), int'(e_v[k]));
          if (SAT) check($sformatf("sat[%0d]", k), int'(o_s[k]), int'(e_s[k]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("reset_i", sx16(o_i[0]), 0);
    check("reset_v", int'(o_v[0]), 0);
    rst = 1'b0;

    // No sync yet: samples must be ignored.
    for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 77, -77, 1'b0);
    check("nosync_pulses", pulses0, 0);
    check("nosync_i", sx16(o_i[0]), 0);

    // Basic window of 16 x (100, -100).
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 16; j++) step(1'b1, 1'b1, 100, -100, 1'b0);
    check("basic_i", sx16(o_i[0]), 100);
    check("basic_q", sx16(o_q[0]), -100);
    check("basic_v", int'(o_v[0]), 1);
    check("basic_i_sh2", sx16(o_i[1]), 400);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("basic_v_pulse", int'(o_v[0]), 0);
    check("basic_hold", sx16(o_i[0]), 100);

    // Resync mid-window: partial 8 samples are discarded.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 8; j++) step(1'b1, 1'b1, 16, -16, 1'b0);
    step(1'b1, 1'b1, 32, -32, 1'b1);
    for (int j = 0; j < 15; j++) step(1'b1, 1'b1, 32, -32, 1'b0);
    check("resync_i", sx16(o_i[0]), 32);
    check("resync_q", sx16(o_q[0]), -32);
    check("resync_v", int'(o_v[0]), 1);

    // Sparse joint valids with I-only cycles in between.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b0, 1000, 0, 1'b0);
      step(1'b1, 1'b1, 48, 0, 1'b0);
    end
    check("sparse_i", sx16(o_i[0]), 48);
    check("sparse_v", int'(o_v[0]), 1);

    // Large samples: overflow of the 16-bit output for SHIFT=2.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 16; j++) step(1'b1, 1'b1, 20000, -20000, 1'b0);
    check("big_i_sh4", sx16(o_i[0]), 20000);
    if (SAT) begin
      check("big_i_sat", sx16(o_i[1]), 32767);
      check("big_q_sat", sx16(o_q[1]), -32768);
      check("big_flag", int'(o_s[1]), 1);
    end else begin
      check("big_i_wrap", sx16(o_i[1]), 14464);
      check("big_q_wrap", sx16(o_q[1]), -14464);
    end

    // DUMP_LEN=1: sync together with a sample dumps that sample.
    step(1'b1, 1'b1, -7, 9, 1'b1);
    check("len1_i", sx16(o_i[2]), -7);
    check("len1_v", int'(o_v[2]), 1);

    // Reset mid-window, then samples without sync are ignored.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 10; j++) step(1'b1, 1'b1, 5, 5, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 5, 5, 1'b0);
    check("midrst_i", sx16(o_i[0]), 0);
    check("midrst_v", int'(o_v[0]), 0);
    rst = 1'b0;
    pulses0 = 0;
    for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 5, 5, 1'b0);
    check("midrst_pulses", pulses0, 0);
    check("midrst_hold", sx16(o_i[0]), 0);

    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
